// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the CPU front end (ifetch_unit) and the main decoder
// (maindec): reset fetch address, canonical NOP, fetch FSM state encoding and
// the instruction bit-slice positions of opcode/funct3.
// -----------------------------------------------------------------------------
package cpu_pkg;

    // First fetch address after reset.
    localparam logic [31:0] CPU_RESET_PC  = 32'h0000_0000;

    // ADDI x0,x0,0 : what the instruction register shows when it holds nothing.
    localparam logic [31:0] CPU_NOP_INSTR = 32'h0000_0013;

    // Instruction field positions (RV32 base encoding).
    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_W   = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_W   = 3;

    // Fetch FSM states.
    //   FETCH_IDLE : no memory request outstanding
    //   FETCH_REQ  : memory request outstanding, waiting for imem_ack
    //   FETCH_BUF  : a fetched word is parked in the skid buffer
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_BUF  = 2'd2
    } fetch_state_t;

    function automatic logic [OPCODE_W-1:0] instr_opcode(input logic [31:0] instr);
        return instr[OPCODE_LSB +: OPCODE_W];
    endfunction

    function automatic logic [FUNCT3_W-1:0] instr_funct3(input logic [31:0] instr);
        return instr[FUNCT3_LSB +: FUNCT3_W];
    endfunction

endpackage

// File: rtl/ifetch_skid.sv
// -----------------------------------------------------------------------------
// ifetch_skid
// One-entry skid buffer holding a fetched instruction word and its address
// while the instruction register is still occupied by a stalled instruction.
//
// Ports
//   clock      in   clock, rising edge
//   reset_     in   asynchronous active-low reset
//   load       in   capture load_data/load_addr, set valid
//   unload     in   entry has been taken by the consumer, clear valid
//   clear      in   flush (redirect); highest priority
//   load_data  in   32-bit instruction word to capture
//   load_addr  in   32-bit address of that word
//   data       out  held instruction word
//   addr       out  held address
//   valid      out  entry is occupied
// -----------------------------------------------------------------------------
module ifetch_skid
    import cpu_pkg::*;
(
    input  logic        clock,
    input  logic        reset_,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  logic [31:0] load_data,
    input  logic [31:0] load_addr,
    output logic [31:0] data,
    output logic [31:0] addr,
    output logic        valid
);

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            data  <= CPU_NOP_INSTR;
            addr  <= CPU_RESET_PC;
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            addr  <= load_addr;
            valid <= 1'b1;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// -----------------------------------------------------------------------------
// ifetch_unit
// Instruction fetch stage. Issues one word read at a time to instruction
// memory, presents the returned word in an instruction register (ir) to the
// decoder, and handles stalls (via a one-entry skid buffer) and redirects
// (flush, drop any in-flight fetch, refetch from the target).
//
// Parameters
//   RESET_PC   first fetch address after reset
//   NOP_INSTR  ir content whenever no valid instruction is held
//
// Ports
//   clock        in   clock, rising edge
//   reset_       in   asynchronous active-low reset
//   imem_req     out  instruction-memory read request
//   imem_addr    out  word-aligned fetch address (valid while imem_req=1)
//   imem_ack     in   one-cycle strobe, imem_rdata valid in the same cycle
//   imem_rdata   in   fetched instruction word
//   stall        in   decoder not accepting ir this cycle
//   redirect     in   taken branch/jump: flush and refetch
//   redirect_pc  in   redirect target, bits [1:0] ignored
//   ir           out  instruction register
//   ir_pc        out  address of the instruction in ir
//   ir_valid     out  ir holds a real instruction (consumed when stall=0)
//   opcode       out  ir[6:0]
//   funct3       out  ir[14:12]
// -----------------------------------------------------------------------------
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = CPU_RESET_PC,
    parameter logic [31:0] NOP_INSTR = CPU_NOP_INSTR
) (
    input  logic                clock,
    input  logic                reset_,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    input  logic                stall,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    output logic [31:0]         ir,
    output logic [31:0]         ir_pc,
    output logic                ir_valid,
    output logic [OPCODE_W-1:0] opcode,
    output logic [FUNCT3_W-1:0] funct3
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  req_addr_reg, req_addr_next;
    logic         drop_reg, drop_next;
    logic [31:0]  ir_reg, ir_next;
    logic [31:0]  ir_pc_reg, ir_pc_next;
    logic         ir_valid_reg, ir_valid_next;

    logic         skid_load, skid_unload, skid_clear;
    logic [31:0]  skid_data, skid_addr;
    logic         skid_valid;

    logic         ir_free;
    logic         ir_consume;
    logic [31:0]  redirect_target;
    logic [31:0]  req_addr_plus4;

    // ir can take a new word this cycle if it is empty or being consumed.
    assign ir_free         = !ir_valid_reg || !stall;
    assign ir_consume      = ir_valid_reg && !stall;
    assign redirect_target = {redirect_pc[31:2], 2'b00};
    // Natural 32-bit overflow gives the required wrap 32'hFFFF_FFFC -> 0.
    assign req_addr_plus4  = req_addr_reg + 32'd4;

    ifetch_skid u_skid (
        .clock     (clock),
        .reset_    (reset_),
        .load      (skid_load),
        .unload    (skid_unload),
        .clear     (skid_clear),
        .load_data (imem_rdata),
        .load_addr (req_addr_reg),
        .data      (skid_data),
        .addr      (skid_addr),
        .valid     (skid_valid)
    );

    // -------------------------------------------------------------------------
    // State register (all fetch state, async reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_reg    <= FETCH_IDLE;
            pc_reg       <= RESET_PC;
            req_addr_reg <= RESET_PC;
            drop_reg     <= 1'b0;
            ir_reg       <= NOP_INSTR;
            ir_pc_reg    <= RESET_PC;
            ir_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            req_addr_reg <= req_addr_next;
            drop_reg     <= drop_next;
            ir_reg       <= ir_next;
            ir_pc_reg    <= ir_pc_next;
            ir_valid_reg <= ir_valid_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        req_addr_next = req_addr_reg;
        drop_next     = drop_reg;
        ir_next       = ir_reg;
        ir_pc_next    = ir_pc_reg;
        ir_valid_next = ir_valid_reg;
        skid_load     = 1'b0;
        skid_unload   = 1'b0;
        skid_clear    = 1'b0;
        imem_req      = (state_reg == FETCH_REQ);
        imem_addr     = req_addr_reg;

        // A consumed instruction leaves ir empty unless a new word replaces it
        // below. ir_pc is left alone; it is meaningless while ir_valid=0.
        if (ir_consume) begin
            ir_next       = NOP_INSTR;
            ir_valid_next = 1'b0;
        end

        if (redirect) begin
            // Redirect wins over everything: flush ir and the skid entry.
            pc_next       = redirect_target;
            ir_next       = NOP_INSTR;
            ir_valid_next = 1'b0;
            skid_clear    = 1'b1;
            if (state_reg == FETCH_REQ) begin
                if (imem_ack) begin
                    // The ack closes the request; its data is simply ignored.
                    state_next = FETCH_IDLE;
                    drop_next  = 1'b0;
                end else begin
                    // Memory still owes us a word: wait for it and discard it.
                    drop_next  = 1'b1;
                end
            end else begin
                state_next = FETCH_IDLE;
            end
        end else begin
            unique case (state_reg)
                FETCH_IDLE: begin
                    if (ir_free) begin
                        req_addr_next = pc_reg;
                        state_next    = FETCH_REQ;
                    end
                end

                FETCH_REQ: begin
                    if (imem_ack) begin
                        if (drop_reg) begin
                            // Word belongs to a pre-redirect fetch.
                            drop_next  = 1'b0;
                            state_next = FETCH_IDLE;
                        end else if (ir_free) begin
                            ir_next       = imem_rdata;
                            ir_pc_next    = req_addr_reg;
                            ir_valid_next = 1'b1;
                            pc_next       = req_addr_plus4;
                            state_next    = FETCH_IDLE;
                        end else begin
                            // ir is held by a stalled instruction: park the word.
                            skid_load  = 1'b1;
                            pc_next    = req_addr_plus4;
                            state_next = FETCH_BUF;
                        end
                    end
                end

                FETCH_BUF: begin
                    if (!skid_valid) begin
                        // Nothing parked (should not happen); recover to IDLE.
                        state_next = FETCH_IDLE;
                    end else if (!stall) begin
                        ir_next       = skid_data;
                        ir_pc_next    = skid_addr;
                        ir_valid_next = 1'b1;
                        skid_unload   = 1'b1;
                        state_next    = FETCH_IDLE;
                    end
                end

                default: begin
                    state_next = FETCH_IDLE;
                end
            endcase
        end
    end

    assign ir       = ir_reg;
    assign ir_pc    = ir_pc_reg;
    assign ir_valid = ir_valid_reg;
    assign opcode   = instr_opcode(ir_reg);
    assign funct3   = instr_funct3(ir_reg);

endmodule

// File: tb/tb_ifetch_unit.sv
// -----------------------------------------------------------------------------
// tb_ifetch_unit
// Directed scenarios for reset, stall, redirect (before and coincident with
// ack), address wrap and reset mid-request, followed by a randomized phase
// where the consumed instruction stream is checked against a program-order
// model: each consumed instruction must be the memory word at the expected
// address, addresses advance by 4 and restart at every redirect target.
// -----------------------------------------------------------------------------
module tb_ifetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset_ = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;

    int total = 0;
    int bad   = 0;

    // memory model controls (written by the main sequence only)
    int mem_lat  = 0;
    bit mem_rand = 0;
    bit stray    = 0;

    // memory model state (written by the responder only)
    int          wait_cnt = 0;
    int          rnd_lat  = 0;
    int          addr_err = 0;
    logic        prev_req = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    always #5 clock = ~clock;

    ifetch_unit dut (
        .clock       (clock),
        .reset_      (reset_),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .opcode      (opcode),
        .funct3      (funct3)
    );

    // Program memory contents.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h0000_A017;
        if (a == 32'h0000_0004) return 32'h0051_2003;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // Memory responder: acks a request after 'lat' waiting cycles, and checks
    // that the address stays stable while the request is held.
    always @(negedge clock) begin
        int lat;
        lat = mem_rand ? rnd_lat : mem_lat;
        imem_ack = 1'b0;
        if (reset_ && prev_req && imem_req && (imem_addr !== prev_addr))
            addr_err++;
        prev_req  = reset_ && imem_req;
        prev_addr = imem_addr;
        if (stray) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
            wait_cnt   = 0;
        end else if (reset_ && imem_req) begin
            if (wait_cnt >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                wait_cnt   = 0;
                rnd_lat    = int'($urandom_range(0, 3));
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next falling edge: sample and drive there.
    task automatic nxt();
        @(negedge clock);
        #1;
    endtask

    initial begin
        int          consumed;
        logic [31:0] exp_pc;
        bit          found;
        consumed = 0;
        exp_pc   = 32'h0;
        found    = 1'b0;

        // ---------------- reset values ----------------
        nxt();
        nxt();
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", imem_addr, RST_PC);
        chk("rst_ir", ir, NOP);
        chk("rst_ir_pc", ir_pc, RST_PC);
        chk("rst_ir_valid", 32'(ir_valid), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'h13);
        reset_ = 1'b1;
        chk("rel_req_low", 32'(imem_req), 32'd0);
        $display("step: reset released");

        // ---------------- first fetch, zero-wait ----------------
        nxt();
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        stall = 1'b1;
        nxt();
        chk("first_ir", ir, 32'h0000_A017);
        chk("first_ir_pc", ir_pc, 32'h0);
        chk("first_ir_valid", 32'(ir_valid), 32'd1);
        chk("first_opcode", 32'(opcode), 32'b0010111);
        chk("first_funct3", 32'(funct3), 32'd2);
        $display("step: first fetch ir=%h", ir);

        // ---------------- stall held while a slow fetch is outstanding ----------------
        stall   = 1'b0;
        mem_lat = 3;
        nxt();
        chk("stl_req", 32'(imem_req), 32'd1);
        chk("stl_addr", imem_addr, 32'h4);
        chk("stl_consumed_valid", 32'(ir_valid), 32'd0);
        chk("stl_consumed_ir", ir, NOP);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk("stl_wait_req", 32'(imem_req), 32'd1);
            chk("stl_wait_addr", imem_addr, 32'h4);
            chk("stl_wait_valid", 32'(ir_valid), 32'd0);
        end
        nxt();
        chk("stl_ir", ir, 32'h0051_2003);
        chk("stl_ir_pc", ir_pc, 32'h4);
        chk("stl_ir_valid", 32'(ir_valid), 32'd1);
        chk("stl_no_req", 32'(imem_req), 32'd0);
        nxt();
        chk("stl_ir_held", ir, 32'h0051_2003);
        chk("stl_held_no_req", 32'(imem_req), 32'd0);
        stall = 1'b0;
        nxt();
        chk("stl_once_valid", 32'(ir_valid), 32'd0);
        chk("stl_next_req", 32'(imem_req), 32'd1);
        chk("stl_next_addr", imem_addr, 32'h8);
        $display("step: stall released, next fetch addr=%h", imem_addr);

        // ---------------- redirect before ack (3-cycle latency) ----------------
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        nxt();
        redirect = 1'b0;
        chk("rd_req_held", 32'(imem_req), 32'd1);
        chk("rd_addr_held", imem_addr, 32'h8);
        chk("rd_valid", 32'(ir_valid), 32'd0);
        nxt();
        nxt();
        nxt();
        chk("rd_drop_req", 32'(imem_req), 32'd0);
        chk("rd_drop_valid", 32'(ir_valid), 32'd0);
        chk("rd_drop_ir", ir, NOP);
        mem_lat = 0;
        nxt();
        chk("rd_new_req", 32'(imem_req), 32'd1);
        chk("rd_new_addr", imem_addr, 32'h0000_0100);
        nxt();
        chk("rd_new_ir", ir, mem_word(32'h100));
        chk("rd_new_ir_pc", ir_pc, 32'h100);
        chk("rd_new_valid", 32'(ir_valid), 32'd1);
        $display("step: redirect before ack, ir_pc=%h", ir_pc);

        // ---------------- redirect coincident with ack ----------------
        nxt();
        chk("rc_req", 32'(imem_req), 32'd1);
        chk("rc_addr", imem_addr, 32'h104);
        redirect    = 1'b1;
        redirect_pc = 32'h2000_0041;
        nxt();
        redirect = 1'b0;
        chk("rc_ir", ir, NOP);
        chk("rc_valid", 32'(ir_valid), 32'd0);
        chk("rc_req_low", 32'(imem_req), 32'd0);
        nxt();
        chk("rc_new_req", 32'(imem_req), 32'd1);
        chk("rc_new_addr", imem_addr, 32'h2000_0040);
        nxt();
        chk("rc_new_ir", ir, mem_word(32'h2000_0040));
        chk("rc_new_ir_pc", ir_pc, 32'h2000_0040);
        $display("step: redirect with ack, ir_pc=%h", ir_pc);

        // ---------------- pc wrap ----------------
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        nxt();
        redirect = 1'b0;
        chk("wr_valid", 32'(ir_valid), 32'd0);
        chk("wr_req_low", 32'(imem_req), 32'd0);
        nxt();
        chk("wr_req", 32'(imem_req), 32'd1);
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        mem_lat = 5;
        nxt();
        chk("wr_ir_pc", ir_pc, 32'hFFFF_FFFC);
        chk("wr_ir", ir, mem_word(32'hFFFF_FFFC));
        nxt();
        chk("wr_next_req", 32'(imem_req), 32'd1);
        chk("wr_next_addr", imem_addr, 32'h0);
        $display("step: wrap, next addr=%h", imem_addr);

        // ---------------- reset in the middle of a request ----------------
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        nxt();
        redirect = 1'b0;
        chk("mr_drop_addr", imem_addr, 32'h0);
        for (int i = 0; i < 20 && !found; i++) begin
            nxt();
            if (imem_req && imem_addr == 32'h40) found = 1'b1;
        end
        chk("mr_req_seen", 32'(found), 32'd1);
        reset_ = 1'b0;
        #1;
        chk("mr_req", 32'(imem_req), 32'd0);
        chk("mr_addr", imem_addr, RST_PC);
        chk("mr_ir", ir, NOP);
        chk("mr_ir_pc", ir_pc, RST_PC);
        chk("mr_valid", 32'(ir_valid), 32'd0);
        mem_lat = 0;
        stray   = 1'b1;
        nxt();
        reset_ = 1'b1;
        stray  = 1'b0;
        nxt();
        chk("mr_stray_valid", 32'(ir_valid), 32'd0);
        chk("mr_stray_ir", ir, NOP);
        chk("mr_first_req", 32'(imem_req), 32'd1);
        chk("mr_first_addr", imem_addr, RST_PC);
        nxt();
        chk("mr_first_ir", ir, 32'h0000_A017);
        chk("mr_first_ir_pc", ir_pc, RST_PC);
        $display("step: reset mid-request recovered, ir=%h", ir);

        // ---------------- randomized stream ----------------
        mem_rand = 1'b1;
        exp_pc   = RST_PC;
        for (int c = 0; c < 1500; c++) begin
            logic        s;
            logic        r;
            logic [31:0] t;
            s = ($urandom_range(0, 99) < 30);
            r = ($urandom_range(0, 99) < 6);
            t = $urandom;
            if ($urandom_range(0, 7) == 0) t = {28'hFFF_FFFF, t[3:0]};
            if (!ir_valid) chk("rnd_empty_ir", ir, NOP);
            if (ir_valid && !s) begin
                chk("rnd_pc", ir_pc, exp_pc);
                chk("rnd_word", ir, mem_word(ir_pc));
                $display("txn pc=%h ir=%h", ir_pc, ir);
                exp_pc = ir_pc + 32'd4;
                consumed++;
            end
            if (r) exp_pc = {t[31:2], 2'b00};
            stall       = s;
            redirect    = r;
            redirect_pc = t;
            nxt();
        end
        stall    = 1'b0;
        redirect = 1'b0;
        chk("rnd_progress", 32'(consumed > 100), 32'd1);
        chk("addr_stable", 32'(addr_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
